// File: rtl/hazard_unit.sv
// hazard_unit: pipeline forwarding, load-use/branch/divide stall control and stall counter.
module hazard_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rsD,
  input  logic [4:0]  rtD,
  input  logic [4:0]  rsE,
  input  logic [4:0]  rtE,
  input  logic [4:0]  writeregE,
  input  logic [4:0]  writeregM,
  input  logic [4:0]  writeregW,
  input  logic        regwriteE,
  input  logic        regwriteM,
  input  logic        regwriteW,
  input  logic        memtoregE,
  input  logic        memtoregM,
  input  logic        branchD,
  input  logic        divE,
  input  logic        div_done,
  output logic        forwardaD,
  output logic        forwardbD,
  output logic [1:0]  forwardaE,
  output logic [1:0]  forwardbE,
  output logic        stallF,
  output logic        stallD,
  output logic        stallE,
  output logic        flushE,
  output logic        div_start,
  output logic [15:0] stall_cnt
);
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
  logic [1:0] state, state_nx;
  logic lwstall, branchstall, divstall;
  always_comb begin
    forwardaE = (rsE != 5'd0 && regwriteM && rsE == writeregM) ? 2'b10 :
                (rsE != 5'd0 && regwriteW && rsE == writeregW) ? 2'b01 : 2'b00;
    forwardbE = (rtE != 5'd0 && regwriteM && rtE == writeregM) ? 2'b10 :
                (rtE != 5'd0 && regwriteW && rtE == writeregW) ? 2'b01 : 2'b00;
    forwardaD = rsD != 5'd0 && regwriteM && rsD == writeregM;
    forwardbD = rtD != 5'd0 && regwriteM && rtD == writeregM;
    lwstall = memtoregE && (rsD == rtE || rtD == rtE);
    branchstall = branchD && ((regwriteE && (writeregE == rsD || writeregE == rtD)) ||
                              (memtoregM && (writeregM == rsD || writeregM == rtD)));
    divstall = (state == IDLE && divE) || (state == BUSY && !div_done);
    stallF = lwstall || branchstall || divstall;
    stallD = stallF;
    stallE = divstall;
    flushE = (lwstall || branchstall) && !divstall;
    div_start = rst && state == IDLE && divE;
    state_nx = (state == IDLE) ? (divE ? BUSY : IDLE) :
               (state == BUSY) ? (div_done ? DONE : BUSY) : IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      stall_cnt <= '0;
    end else begin
      state <= state_nx;
      if (stallF && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed and randomized checks of hazard_unit against a behavioural model.
module tb_hazard_unit;
  logic clk = 0, rst = 0;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, branchD, divE, div_done;
  logic forwardaD, forwardbD, stallF, stallD, stallE, flushE, div_start;
  logic [1:0] forwardaE, forwardbE;
  logic [15:0] stall_cnt;
  int errors = 0, checks = 0;
  bit m_busy = 0, m_done = 0;
  int m_cnt = 0;

  hazard_unit dut (.clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM), .branchD(branchD), .divE(divE),
    .div_done(div_done), .forwardaD(forwardaD), .forwardbD(forwardbD),
    .forwardaE(forwardaE), .forwardbE(forwardbE), .stallF(stallF), .stallD(stallD),
    .stallE(stallE), .flushE(flushE), .div_start(div_start), .stall_cnt(stall_cnt));

  always #5 clk = ~clk;

  function automatic logic [1:0] m_fe(input logic [4:0] r);
    if (r != 0 && regwriteM && r == writeregM) return 2'b10;
    if (r != 0 && regwriteW && r == writeregW) return 2'b01;
    return 2'b00;
  endfunction
  function automatic logic m_fd(input logic [4:0] r);
    return r != 0 && regwriteM && r == writeregM;
  endfunction
  function automatic logic m_lw();
    return memtoregE && (rsD == rtE || rtD == rtE);
  endfunction
  function automatic logic m_br();
    return branchD && ((regwriteE && (writeregE == rsD || writeregE == rtD)) ||
                       (memtoregM && (writeregM == rsD || writeregM == rtD)));
  endfunction
  function automatic logic m_dv();
    return (!m_busy && !m_done && divE) || (m_busy && !div_done);
  endfunction

  task automatic clear_inputs();
    {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
    {regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, branchD, divE, div_done} = '0;
  endtask

  // advance the model by one clock with the current inputs, then step the DUT
  task automatic tick();
    if ((m_lw() || m_br() || m_dv()) && m_cnt < 65535) m_cnt++;
    if (m_done) m_done = 0;
    else if (m_busy) begin
      if (div_done) begin m_busy = 0; m_done = 1; end
    end else if (divE) m_busy = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    divE = 1;
    #12;
    checks++; if (stall_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt got=%h exp=0", stall_cnt); end
    checks++; if (div_start !== 1'b0) begin errors++; $display("FAIL reset_div_start got=%b exp=0", div_start); end
    checks++; if (stallE !== 1'b1) begin errors++; $display("FAIL reset_stallE_tracks got=%b exp=1", stallE); end
    divE = 0;
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_forward();
    clear_inputs();
    rsE = 5; writeregM = 5; regwriteM = 1; writeregW = 5; regwriteW = 1; rtE = 5;
    #2;
    checks++; if (forwardaE !== 2'b10) begin errors++; $display("FAIL fwd_mem got=%b exp=10", forwardaE); end
    checks++; if (forwardbE !== 2'b10) begin errors++; $display("FAIL fwdb_mem got=%b exp=10", forwardbE); end
    regwriteM = 0; #1;
    checks++; if (forwardaE !== 2'b01) begin errors++; $display("FAIL fwd_wb got=%b exp=01", forwardaE); end
    rsE = 0; #1;
    checks++; if (forwardaE !== 2'b00) begin errors++; $display("FAIL fwd_zero got=%b exp=00", forwardaE); end
    checks++; if (forwardbE !== 2'b01) begin errors++; $display("FAIL fwdb_wb got=%b exp=01", forwardbE); end
    tick();
  endtask

  task automatic test_load_use();
    clear_inputs();
    memtoregE = 1; rtE = 8; rsD = 8;
    for (int k = 0; k < 3; k++) begin
      #2;
      checks++; if ({stallF, stallD, flushE, stallE} !== 4'b1110) begin
        errors++; $display("FAIL lw_stall[%0d] got=%b exp=1110", k, {stallF, stallD, flushE, stallE}); end
      checks++; if (stall_cnt !== m_cnt[15:0]) begin
        errors++; $display("FAIL lw_cnt[%0d] got=%0d exp=%0d", k, stall_cnt, m_cnt); end
      tick();
    end
    checks++; if (stall_cnt !== m_cnt[15:0]) begin errors++; $display("FAIL lw_cnt_end got=%0d exp=%0d", stall_cnt, m_cnt); end
  endtask

  task automatic test_branch();
    clear_inputs();
    branchD = 1; rsD = 3; regwriteE = 1; writeregE = 3;
    #2;
    checks++; if ({stallD, flushE} !== 2'b11) begin errors++; $display("FAIL br_stall got=%b exp=11", {stallD, flushE}); end
    tick();
    regwriteE = 0; writeregE = 0; regwriteM = 1; writeregM = 3; memtoregM = 0;
    #2;
    checks++; if ({stallD, flushE, forwardaD} !== 3'b001) begin
      errors++; $display("FAIL br_resolve got=%b exp=001", {stallD, flushE, forwardaD}); end
    tick();
  endtask

  task automatic test_divide();
    clear_inputs();
    divE = 1;
    #2;
    checks++; if ({div_start, stallE} !== 2'b11) begin errors++; $display("FAIL div_c0 got=%b exp=11", {div_start, stallE}); end
    tick();
    for (int k = 1; k < 4; k++) begin
      #2;
      checks++; if ({div_start, stallE} !== 2'b01) begin errors++; $display("FAIL div_c%0d got=%b exp=01", k, {div_start, stallE}); end
      tick();
    end
    div_done = 1; #2;
    checks++; if ({stallE, stallF} !== 2'b00) begin errors++; $display("FAIL div_done got=%b exp=00", {stallE, stallF}); end
    tick();
    div_done = 0; #2;
    checks++; if ({div_start, stallE} !== 2'b00) begin errors++; $display("FAIL div_donestate got=%b exp=00", {div_start, stallE}); end
    tick();
    divE = 0; tick();
  endtask

  task automatic test_div_lw();
    clear_inputs();
    divE = 1; tick();
    memtoregE = 1; rtE = 8; rsD = 8; #2;
    checks++; if ({flushE, stallE, stallF} !== 3'b011) begin
      errors++; $display("FAIL div_lw got=%b exp=011", {flushE, stallE, stallF}); end
    tick();
    memtoregE = 0; div_done = 1; tick();
    div_done = 0; divE = 0; tick();
  endtask

  task automatic test_reset_busy();
    clear_inputs();
    divE = 1; tick(); tick();
    rst = 0; m_busy = 0; m_done = 0; m_cnt = 0; #1;
    checks++; if (stall_cnt !== 16'h0) begin errors++; $display("FAIL rstbusy_cnt got=%h exp=0", stall_cnt); end
    checks++; if ({div_start, stallE} !== 2'b01) begin errors++; $display("FAIL rstbusy_idle got=%b exp=01", {div_start, stallE}); end
    @(negedge clk); rst = 1; #1;
    checks++; if (div_start !== 1'b1) begin errors++; $display("FAIL rstbusy_restart got=%b exp=1", div_start); end
    @(posedge clk); #1;
    m_busy = 1; m_cnt = 1;
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL rstbusy_cnt1 got=%0d exp=1", stall_cnt); end
    div_done = 1; tick();
    div_done = 0; divE = 0; tick();
  endtask

  task automatic test_random();
    logic [12:0] got, exp;
    for (int i = 0; i < 400; i++) begin
      rsD = 5'($urandom_range(0, 3)); rtD = 5'($urandom_range(0, 3));
      rsE = 5'($urandom_range(0, 3)); rtE = 5'($urandom_range(0, 3));
      writeregE = 5'($urandom_range(0, 3)); writeregM = 5'($urandom_range(0, 3));
      writeregW = 5'($urandom_range(0, 3));
      {regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, branchD} = 6'($urandom);
      divE = ($urandom_range(0, 3) == 0); div_done = ($urandom_range(0, 3) == 0);
      #2;
      got = {forwardaD, forwardbD, forwardaE, forwardbE, stallF, stallD, stallE, flushE, div_start, 2'b00};
      exp = {m_fd(rsD), m_fd(rtD), m_fe(rsE), m_fe(rtE), m_lw() || m_br() || m_dv(),
             m_lw() || m_br() || m_dv(), m_dv(), (m_lw() || m_br()) && !m_dv(),
             !m_busy && !m_done && divE, 2'b00};
      checks++; if (got !== exp) begin errors++; $display("FAIL rand[%0d] got=%b exp=%b", i, got, exp); end
      checks++; if (stall_cnt !== m_cnt[15:0]) begin errors++; $display("FAIL rand_cnt[%0d] got=%0d exp=%0d", i, stall_cnt, m_cnt); end
      tick();
    end
    clear_inputs(); div_done = 1; tick(); div_done = 0; tick(); tick();
  endtask

  task automatic test_saturation();
    clear_inputs();
    memtoregE = 1; rtE = 8; rsD = 8;
    for (int i = 0; i < 70000; i++) tick();
    checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat got=%h exp=ffff", stall_cnt); end
    tick(); tick();
    checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got=%h exp=ffff", stall_cnt); end
    checks++; if (stall_cnt !== m_cnt[15:0]) begin errors++; $display("FAIL sat_model got=%h exp=%h", stall_cnt, m_cnt); end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_branch();
    test_divide();
    test_div_lw();
    test_reset_busy();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
